// File: rtl/serial_result_collector_if.sv
// Interface bundle for serial_result_collector: serial input stream, flag
// control and the valid/ready output side. The optional statistics outputs
// exist only when SERIAL_COLLECTOR_STATS_EN is defined.
interface serial_result_collector_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             start_c;
    logic             c;
    logic             out_ready;
    logic             clear_flags;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] fifo_count;
    logic             busy;
    logic             overflow;
    logic             frame_abort;
`ifdef SERIAL_COLLECTOR_STATS_EN
    logic [15:0]      words_rx;
    logic [15:0]      words_drop;

    modport slave (
        input  start_c, c, out_ready, clear_flags,
        output out_valid, out_data, fifo_count, busy, overflow, frame_abort,
        output words_rx, words_drop
    );
    modport master (
        output start_c, c, out_ready, clear_flags,
        input  out_valid, out_data, fifo_count, busy, overflow, frame_abort,
        input  words_rx, words_drop
    );
`else
    modport slave (
        input  start_c, c, out_ready, clear_flags,
        output out_valid, out_data, fifo_count, busy, overflow, frame_abort
    );
    modport master (
        output start_c, c, out_ready, clear_flags,
        input  out_valid, out_data, fifo_count, busy, overflow, frame_abort
    );
`endif
endinterface

// File: rtl/serial_result_collector.sv
// serial_result_collector: deserializes LSB-first WIDTH-bit result frames
// (framed by start_c) into words, buffers them in a DEPTH-entry FIFO and
// presents them on a valid/ready interface. Sticky flags report dropped
// words (overflow) and truncated frames (frame_abort).
// Optional feature macro: SERIAL_COLLECTOR_STATS_EN adds saturating 16-bit
// words_rx / words_drop counters.
module serial_result_collector #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    serial_result_collector_if.slave bus
);
    localparam int                PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0]  LAST   = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(DEPTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_bit0;
    logic [WIDTH-1:0]   w_captured;
    logic [WIDTH-1:0]   w_word;
    logic               w_done;
    logic               w_abort;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_frame_abort;
    logic               w_valid;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;

    // Frame FSM state, bit counter and partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: capture bits, detect completed words and restarts.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_shift_nxt       = r_shift;
        w_done            = 1'b0;
        w_abort           = 1'b0;
        w_bit0            = '0;
        w_bit0[0]         = bus.c;
        w_captured        = r_shift;
        w_captured[r_cnt] = bus.c;
        w_word            = w_captured;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_c) begin
                    if (WIDTH == 1) begin
                        // A one-bit word is complete in its start cycle.
                        w_done      = 1'b1;
                        w_word      = w_bit0;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_shift_nxt = w_bit0;
                        w_cnt_nxt   = BIT_W'(1);
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (bus.start_c) begin
                    // New frame overrides the partial one; this c is its bit 0.
                    w_abort     = 1'b1;
                    w_shift_nxt = w_bit0;
                    w_cnt_nxt   = BIT_W'(1);
                end else if (r_cnt == LAST) begin
                    w_done      = 1'b1;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_shift_nxt = w_captured;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && bus.out_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push_ok = w_done && ((r_count != FULL) || w_pop);
    assign w_drop    = w_done && !w_push_ok;

    // FIFO storage; stale entries are harmless because pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // FIFO pointers, occupancy and sticky flags (a set beats a clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            r_overflow    <= w_drop  || (r_overflow    && !bus.clear_flags);
            r_frame_abort <= w_abort || (r_frame_abort && !bus.clear_flags);
        end
    end

    assign bus.out_valid   = w_valid;
    assign bus.out_data    = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.fifo_count  = r_count;
    assign bus.busy        = (r_state == S_SHIFT);
    assign bus.overflow    = r_overflow;
    assign bus.frame_abort = r_frame_abort;

`ifdef SERIAL_COLLECTOR_STATS_EN
    logic [15:0] r_words_rx;
    logic [15:0] r_words_drop;

    // Saturating counters of completed and dropped words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_words_rx   <= '0;
            r_words_drop <= '0;
        end else begin
            if (w_done && (r_words_rx != 16'hFFFF))   r_words_rx   <= r_words_rx + 1'b1;
            if (w_drop && (r_words_drop != 16'hFFFF)) r_words_drop <= r_words_drop + 1'b1;
        end
    end

    assign bus.words_rx   = r_words_rx;
    assign bus.words_drop = r_words_drop;
`endif
endmodule

// File: tb/tb_serial_result_collector.sv
// Directed bench for serial_result_collector (WIDTH=4, DEPTH=4).
module tb_serial_result_collector;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_result_collector_if #(.WIDTH(4), .CNT_W(3)) bus ();

    serial_result_collector #(.WIDTH(4), .DEPTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one 4-bit frame LSB first; optionally hold out_ready on the last bit.
    task automatic send_frame(input logic [3:0] w, input logic ready_last);
        for (int i = 0; i < 4; i++) begin
            bus.start_c   = (i == 0);
            bus.c         = w[i];
            bus.out_ready = (i == 3) ? ready_last : 1'b0;
            tick();
        end
        bus.start_c   = 1'b0;
        bus.c         = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.start_c     = 1'b0;
        bus.c           = 1'b0;
        bus.out_ready   = 1'b0;
        bus.clear_flags = 1'b0;
        tick();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_abort", bus.frame_abort, 0);
        reset = 1'b0;

        // Single frame 4'hD: bits 1,0,1,1.
        bus.start_c = 1'b1; bus.c = 1'b1;
        tick();
        bus.start_c = 1'b0; bus.c = 1'b0;
        check("t1_busy", bus.busy, 1);
        check("t1_valid_early", bus.out_valid, 0);
        tick();
        bus.c = 1'b1;
        tick();
        tick();
        bus.c = 1'b0;
        check("t1_valid", bus.out_valid, 1);
        check("t1_data", bus.out_data, 4'hD);
        check("t1_count", bus.fifo_count, 1);
        check("t1_idle", bus.busy, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t1_empty", bus.out_valid, 0);

        // Back-to-back frames, then drain one per cycle.
        send_frame(4'h3, 1'b0);
        send_frame(4'hA, 1'b0);
        send_frame(4'hF, 1'b0);
        check("t2_count", bus.fifo_count, 3);
        check("t2_ovf", bus.overflow, 0);
        bus.out_ready = 1'b1;
        check("t2_d0", bus.out_data, 4'h3);
        tick();
        check("t2_d1", bus.out_data, 4'hA);
        tick();
        check("t2_d2", bus.out_data, 4'hF);
        tick();
        check("t2_empty", bus.out_valid, 0);
        check("t2_count0", bus.fifo_count, 0);
        bus.out_ready = 1'b0;

        // Overflow: fifth word dropped.
        for (int k = 1; k <= 5; k++) send_frame(4'(k), 1'b0);
        check("t3_count", bus.fifo_count, 4);
        check("t3_ovf", bus.overflow, 1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t3_drain", bus.out_data, k);
            tick();
        end
        bus.out_ready = 1'b0;
        check("t3_empty", bus.out_valid, 0);
        check("t3_ovf_hold", bus.overflow, 1);
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        check("t3_ovf_clr", bus.overflow, 0);

        // Full FIFO with push and pop on the same edge.
        for (int k = 1; k <= 4; k++) send_frame(4'(k), 1'b0);
        check("t4_full", bus.fifo_count, 4);
        send_frame(4'h9, 1'b1);
        check("t4_ovf", bus.overflow, 0);
        check("t4_count", bus.fifo_count, 4);
        check("t4_head", bus.out_data, 4'h2);
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t4_last", bus.out_data, 4'h9);
        tick();
        bus.out_ready = 1'b0;
        check("t4_empty", bus.out_valid, 0);

        // Aborted frame followed by a complete frame 4'h6.
        bus.start_c = 1'b1; bus.c = 1'b1;
        tick();
        bus.start_c = 1'b0; bus.c = 1'b1;
        tick();
        check("t5_abort_pre", bus.frame_abort, 0);
        send_frame(4'h6, 1'b0);
        check("t5_abort", bus.frame_abort, 1);
        check("t5_count", bus.fifo_count, 1);
        check("t5_data", bus.out_data, 4'h6);
        check("t5_busy", bus.busy, 0);
        bus.out_ready   = 1'b1;
        bus.clear_flags = 1'b1;
        tick();
        bus.out_ready   = 1'b0;
        bus.clear_flags = 1'b0;
        check("t5_empty", bus.out_valid, 0);
        check("t5_abort_clr", bus.frame_abort, 0);

        // Reset mid-frame with one word buffered and the abort flag set.
        send_frame(4'h7, 1'b0);
        bus.start_c = 1'b1; bus.c = 1'b0;
        tick();
        bus.start_c = 1'b1; bus.c = 1'b0;
        tick();
        bus.start_c = 1'b0; bus.c = 1'b1;
        tick();
        check("t6_busy", bus.busy, 1);
        check("t6_abort", bus.frame_abort, 1);
        check("t6_count", bus.fifo_count, 1);
        reset = 1'b1;
        bus.c = 1'b0;
        tick();
        reset = 1'b0;
        check("t6_rcount", bus.fifo_count, 0);
        check("t6_rvalid", bus.out_valid, 0);
        check("t6_rbusy", bus.busy, 0);
        check("t6_rovf", bus.overflow, 0);
        check("t6_rabort", bus.frame_abort, 0);
        send_frame(4'h5, 1'b0);
        check("t6_count1", bus.fifo_count, 1);
        check("t6_data", bus.out_data, 4'h5);
        check("t6_abort0", bus.frame_abort, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_result_collector.md
Name: serial_result_collector

Overview:
- Downstream consumer of the serial adder's result stream (`c` plus the `start_c` frame pulse).
- Deserializes each WIDTH-bit sum into a parallel word and buffers it in a small FIFO.
- Presents buffered words on a valid/ready output interface.
- Flags overflow and aborted (truncated) frames so the consumer side can detect lost results.

Parameters:
- WIDTH, 4: bits per serial result word; must match the adder word width.
- DEPTH, 4: FIFO entries; a power of two, at least 2.
- CNT_W, 3: width of `fifo_count`; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_c  input  1  frame-start pulse; high in the same cycle as bit 0 on `c`.
- c  input  1  serial result bit, LSB first, one bit per clock.
- out_ready  input  1  consumer accepts `out_data` when `out_valid` && `out_ready`.
- clear_flags  input  1  synchronous clear of the sticky error flags.
- out_valid  output  1  FIFO head word is valid.
- out_data  output  WIDTH  FIFO head word.
- fifo_count  output  CNT_W  number of words held, 0..DEPTH.
- busy  output  1  a frame is being shifted in.
- overflow  output  1  sticky; a completed word was dropped because the FIFO was full.
- frame_abort  output  1  sticky; `start_c` arrived before the current frame completed.

Behaviour:
- Reset (synchronous, active-high):
  - FSM returns to IDLE; bit counter = 0; shift register = 0.
  - FIFO is emptied: pointers = 0, `fifo_count` = 0, `out_valid` = 0, `out_data` = 0.
  - `busy` = 0, `overflow` = 0, `frame_abort` = 0.
  - Reset asserted mid-frame discards the partial word; no flag is set.
- FSM, state IDLE:
  - `busy` = 0; `c` is ignored unless `start_c` = 1.
  - On `start_c`=1: capture `c` into bit 0, set bit counter to 1, go to SHIFT.
  - If WIDTH = 1, the word completes in this same cycle.
- FSM, state SHIFT:
  - `busy` = 1; each cycle capture `c` into bit[counter] and increment the counter.
  - When bit WIDTH-1 is captured, the word is complete: push it and return to IDLE.
- Start pulse during SHIFT:
  - Discard the partial word and set `frame_abort`.
  - Restart: this cycle's `c` is bit 0 of the new frame and the counter is set to 1.
- Latency:
  - Bit 0 in cycle t gives the last bit in cycle t+WIDTH-1.
  - The word is written on the edge closing that cycle.
  - `out_valid` rises in cycle t+WIDTH (registered output, no fall-through).
- Back-to-back frames: `start_c` in the cycle right after the last bit of the previous frame is legal and carries no gap penalty.
- FIFO push:
  - Accepted when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped, `overflow` is set, and FIFO contents are unchanged.
- FIFO pop: occurs when `out_valid` && `out_ready`; the head advances on that edge.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- Pointer wrap-around is modulo DEPTH; full and empty are distinguished via `fifo_count`.
- Output stability: `out_data` holds stable while `out_valid`=1 && `out_ready`=0.
- `out_ready` while empty has no effect.
- Flag clearing:
  - `clear_flags` clears both sticky flags.
  - If a set event occurs in the same cycle as `clear_flags`, the set wins.

Optional Feature:
- Macro: SERIAL_COLLECTOR_STATS_EN.
- When defined, two extra outputs are added, each 16 bits, both saturating at 16'hFFFF and cleared by reset:
  - `words_rx` counts completed frames, whether accepted or dropped.
  - `words_drop` counts words dropped on overflow.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset and single frame: reset for 2 cycles, then `start_c`=1 with bits 1,0,1,1 on `c` (LSB first) → `out_valid`=1 four cycles after `start_c`, `out_data`=4'hD, `fifo_count`=1.
- Back-to-back frames: frames 4'h3, 4'hA, 4'hF with no gap and `out_ready`=0 → `fifo_count`=3; then raise `out_ready` → 3, A, F drained one per cycle, then `out_valid`=0.
- Overflow: 5 frames (1,2,3,4,5) with `out_ready`=0 → `fifo_count`=4, `overflow`=1, drained data 1,2,3,4; `clear_flags` → `overflow`=0.
- Full with simultaneous push/pop: with 4 words held, complete frame 4'h9 while `out_ready`=1 → `overflow` stays 0, `fifo_count` stays 4, 4'h9 is the last word drained.
- Abort: `start_c` issued, 2 bits sent, then `start_c` again followed by frame 4'h6 → `frame_abort`=1 and the only word stored is 4'h6.
- Reset mid-frame: assert `reset` after 2 bits with 1 word buffered → `fifo_count`=0, `out_valid`=0, `busy`=0, flags 0; the next full frame 4'h5 is received correctly.
